// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared field indices, FSM encoding and list width for the MEM stage
package mem_stage_pkg;

  localparam int WB_REG_WRITE = 0;
  localparam int WB_SEL_MEM   = 1;
  localparam int WB_SEL_PC    = 2;

  localparam int M_READ  = 0;
  localparam int M_WRITE = 1;
  localparam int M_MULTI = 2;

  localparam int LIST_W = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_MULTI = 1'b1;

  // Memory data wins over pc_plus1, which wins over the ALU result.
  function automatic logic [15:0] select_wb_data(input logic [2:0] wb,
                                                 input logic [15:0] rdata,
                                                 input logic [15:0] pc_plus1,
                                                 input logic [15:0] alu_out);
    if (wb[WB_SEL_MEM])     return rdata;
    else if (wb[WB_SEL_PC]) return pc_plus1;
    else                    return alu_out;
  endfunction

endpackage

// File: rtl/mem_stage_lowest_set_bit.sv
// rtl/mem_stage_lowest_set_bit.sv - index of the lowest set bit of the LM/SM register list
module lowest_set_bit
  import mem_stage_pkg::*;
(
  input  logic [LIST_W-1:0] bits,
  output logic [2:0]        index,
  output logic              found,
  output logic              many
);

  always_comb begin
    index = 3'd0;
    found = 1'b0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (bits[i]) begin
        index = i[2:0];
        found = 1'b1;
      end
    end
  end

  // More than one bit set means another access follows this one.
  assign many = |(bits & (bits - LIST_W'(1)));

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage with single loads/stores and multi-cycle LM/SM sequencing
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [2:0]  ex_wb,
  input  logic [2:0]  ex_m,
  input  logic [15:0] ex_alu_out,
  input  logic [15:0] ex_write_data,
  input  logic [2:0]  ex_rd,
  input  logic [15:0] ex_pc_plus1,
  input  logic [15:0] ex_lm_addr,
  input  logic [15:0] ex_inst,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [2:0]  sm_sel,
  input  logic [15:0] sm_data,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_we,
  output logic        wb_z_we,
  output logic        wb_z,
  output logic [2:0]  wb_rd,
  output logic [15:0] wb_data
);

  logic [0:0]        state;
  logic [LIST_W-1:0] list_q;
  logic [15:0]       addr_q;
  logic              lm_q;
  logic              sm_q;

  logic [LIST_W-1:0] list_in;
  logic              is_single;
  logic              is_multi;
  logic [2:0]        sel_idx;
  logic              sel_found;
  logic              sel_many;
  logic              unused_inst_hi;

  assign list_in        = ex_inst[LIST_W-1:0];
  assign is_single      = ex_valid & ~ex_m[M_MULTI];
  assign is_multi       = ex_valid &  ex_m[M_MULTI];
  assign unused_inst_hi = ^ex_inst[15:LIST_W];

  lowest_set_bit u_lowest_set_bit (
    .bits  (list_q),
    .index (sel_idx),
    .found (sel_found),
    .many  (sel_many)
  );

  always_comb begin
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    mem_we    = 1'b0;
    sm_sel    = 3'd0;
    stall     = 1'b0;
    if (!reset) begin
      if (state == ST_MULTI) begin
        mem_addr = addr_q;
        sm_sel   = sel_idx;
        stall    = sel_many;
        if (sm_q) begin
          mem_we    = sel_found;
          mem_wdata = sm_data;
        end
      end else if (is_single) begin
        mem_addr  = ex_alu_out;
        mem_wdata = ex_write_data;
        mem_we    = ex_m[M_WRITE];
      end else if (is_multi && list_in != '0) begin
        stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      list_q   <= '0;
      addr_q   <= 16'h0000;
      lm_q     <= 1'b0;
      sm_q     <= 1'b0;
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_z_we  <= 1'b0;
      wb_z     <= 1'b0;
      wb_rd    <= 3'd0;
      wb_data  <= 16'h0000;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_z_we  <= 1'b0;
      wb_z     <= 1'b0;
      wb_rd    <= 3'd0;
      wb_data  <= 16'h0000;
      if (state == ST_MULTI) begin
        wb_valid <= 1'b1;
        if (lm_q) begin
          wb_we   <= 1'b1;
          wb_rd   <= sel_idx;
          wb_data <= mem_rdata;
        end
        list_q[sel_idx] <= 1'b0;
        addr_q          <= addr_q + 16'h0001;
        if (!sel_many) state <= ST_IDLE;
      end else if (is_single) begin
        wb_valid <= 1'b1;
        wb_we    <= ex_wb[WB_REG_WRITE];
        wb_rd    <= ex_rd;
        wb_data  <= select_wb_data(ex_wb, mem_rdata, ex_pc_plus1, ex_alu_out);
        wb_z_we  <= ex_m[M_READ];
        wb_z     <= ex_m[M_READ] & (mem_rdata == 16'h0000);
      end else if (is_multi) begin
        // An empty register list retires as a NOP without entering MULTI.
        if (list_in != '0) begin
          state  <= ST_MULTI;
          list_q <= list_in;
          addr_q <= ex_lm_addr;
          lm_q   <= ex_m[M_READ];
          sm_q   <= ex_m[M_WRITE] & ~ex_m[M_READ];
        end else begin
          wb_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - table and scoreboard bench for mem_stage
module tb_mem_stage;

  typedef struct packed {
    logic        v;
    logic        we;
    logic [2:0]  rd;
    logic [15:0] data;
    logic        z_we;
    logic        z;
  } wb_t;

  typedef struct {
    logic        v;
    logic [2:0]  wb;
    logic [2:0]  m;
    logic [2:0]  rd;
    logic [15:0] alu;
    logic [15:0] wd;
    logic [15:0] pc1;
    logic [15:0] inst;
    logic        e_stall;
    logic        e_we;
    logic [15:0] e_addr;
    wb_t         e_wb;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [2:0]  ex_wb, ex_m, ex_rd;
  logic [15:0] ex_alu_out, ex_write_data, ex_pc_plus1, ex_lm_addr, ex_inst;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, sm_data, wb_data;
  logic        mem_we, stall, wb_valid, wb_we, wb_z_we, wb_z;
  logic [2:0]  sm_sel, wb_rd;

  logic        mem_init;
  logic [15:0] mem [0:65535];

  int   n_cmp = 0;
  int   n_bad = 0;
  wb_t  exp_q[$];
  vec_t vt[9];

  always #5 clock = ~clock;

  mem_stage dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_wb(ex_wb), .ex_m(ex_m),
    .ex_alu_out(ex_alu_out), .ex_write_data(ex_write_data), .ex_rd(ex_rd),
    .ex_pc_plus1(ex_pc_plus1), .ex_lm_addr(ex_lm_addr), .ex_inst(ex_inst),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .sm_sel(sm_sel), .sm_data(sm_data), .stall(stall), .wb_valid(wb_valid), .wb_we(wb_we),
    .wb_z_we(wb_z_we), .wb_z(wb_z), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  function automatic logic [15:0] dflt(input logic [15:0] a);
    return a ^ 16'h0010;
  endfunction

  function automatic logic [15:0] rf_val(input logic [2:0] i);
    return 16'hA000 + 16'h0111 * {13'd0, i};
  endfunction

  function automatic wb_t mk_wb(input logic v, input logic we, input logic [2:0] rd,
                                input logic [15:0] d, input logic zwe, input logic z);
    wb_t r;
    r.v = v; r.we = we; r.rd = rd; r.data = d; r.z_we = zwe; r.z = z;
    return r;
  endfunction

  // Memory model: fill with a known pattern once, then take DUT writes.
  always @(posedge clock) begin
    if (mem_init) begin
      for (int a = 0; a < 65536; a++) mem[a] <= dflt(a[15:0]);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always_comb mem_rdata = mem[mem_addr];
  assign sm_data = rf_val(sm_sel);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    wb_t e;
    wb_t a;
    @(posedge clock);
    #1;
    a = mk_wb(wb_valid, wb_we, wb_rd, wb_data, wb_z_we, wb_z);
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL wb_scoreboard_empty: got %h expected none", a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        n_bad++;
        $display("FAIL wb_record: got %h expected %h", a, e);
      end
    end
  endtask

  task automatic set_ex(input logic v, input logic [2:0] wb, input logic [2:0] m,
                        input logic [2:0] rd, input logic [15:0] alu, input logic [15:0] wd,
                        input logic [15:0] pc1, input logic [15:0] inst, input logic [15:0] lma);
    ex_valid = v; ex_wb = wb; ex_m = m; ex_rd = rd; ex_alu_out = alu;
    ex_write_data = wd; ex_pc_plus1 = pc1; ex_inst = inst; ex_lm_addr = lma;
  endtask

  task automatic idle_cycle();
    set_ex(1'b0, 3'b000, 3'b000, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    #1;
    chk("idle_stall", {31'd0, stall}, 32'd0);
    chk("idle_sm_sel", {29'd0, sm_sel}, 32'd0);
    exp_q.push_back(mk_wb(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0));
    tick();
  endtask

  // Runs one LM/SM from IDLE; abort_after >= 0 asserts reset after that many accesses.
  task automatic run_multi(input string tag, input logic lm, input logic [7:0] l,
                           input logic [15:0] base, input int abort_after);
    logic [15:0] addr;
    int remaining;
    int k;
    int stall_cnt;
    int cycles;
    addr = base; remaining = $countones(l); k = 0; stall_cnt = 0; cycles = 1;
    set_ex(1'b1, lm ? 3'b011 : 3'b000, lm ? 3'b101 : 3'b110, 3'd0, 16'h7777,
           16'h5555, 16'h0009, {8'h00, l}, base);
    #1;
    chk({tag, "_start_stall"}, {31'd0, stall}, 32'd1);
    chk({tag, "_start_we"}, {31'd0, mem_we}, 32'd0);
    stall_cnt += int'(stall);
    exp_q.push_back(mk_wb(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0));
    tick();
    ex_alu_out = 16'hDEAD;
    for (int i = 0; i < 8; i++) begin
      if (l[i] && k != abort_after) begin
        #1;
        cycles++;
        stall_cnt += int'(stall);
        chk({tag, "_addr"}, {16'd0, mem_addr}, {16'd0, addr});
        chk({tag, "_sm_sel"}, {29'd0, sm_sel}, i);
        chk({tag, "_stall"}, {31'd0, stall}, {31'd0, remaining >= 2});
        chk({tag, "_we"}, {31'd0, mem_we}, {31'd0, !lm});
        if (!lm) chk({tag, "_wdata"}, {16'd0, mem_wdata}, {16'd0, rf_val(i[2:0])});
        if (lm) exp_q.push_back(mk_wb(1'b1, 1'b1, i[2:0], dflt(addr), 1'b0, 1'b0));
        else    exp_q.push_back(mk_wb(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0));
        tick();
        if (!lm) chk({tag, "_stored"}, {16'd0, mem[addr]}, {16'd0, rf_val(i[2:0])});
        addr = addr + 16'h0001;
        remaining--;
        k++;
      end
    end
    if (abort_after >= 0) begin
      reset = 1'b1;
      #1;
      chk({tag, "_rst_stall"}, {31'd0, stall}, 32'd0);
      chk({tag, "_rst_we"}, {31'd0, mem_we}, 32'd0);
      exp_q.push_back(mk_wb(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0));
      tick();
      reset = 1'b0;
      idle_cycle();
      set_ex(1'b1, 3'b001, 3'b000, 3'd6, 16'h4321, 16'h0, 16'h0, 16'h0, 16'h0);
      #1;
      chk({tag, "_post_we"}, {31'd0, mem_we}, 32'd0);
      chk({tag, "_post_addr"}, {16'd0, mem_addr}, 32'h4321);
      exp_q.push_back(mk_wb(1'b1, 1'b1, 3'd6, 16'h4321, 1'b0, 1'b0));
      tick();
    end else begin
      chk({tag, "_stall_cycles"}, stall_cnt, $countones(l));
      chk({tag, "_total_cycles"}, cycles, $countones(l) + 1);
    end
    idle_cycle();
  endtask

  initial begin
    vt[0] = '{1'b1, 3'b011, 3'b001, 3'd3, 16'h0010, 16'h0000, 16'h0005, 16'h0000,
              1'b0, 1'b0, 16'h0010, mk_wb(1'b1, 1'b1, 3'd3, 16'h0000, 1'b1, 1'b1)};
    vt[1] = '{1'b1, 3'b011, 3'b001, 3'd4, 16'h0031, 16'h0000, 16'h0006, 16'h0000,
              1'b0, 1'b0, 16'h0031, mk_wb(1'b1, 1'b1, 3'd4, 16'h0021, 1'b1, 1'b0)};
    vt[2] = '{1'b1, 3'b000, 3'b010, 3'd2, 16'h0020, 16'hBEEF, 16'h0007, 16'h0000,
              1'b0, 1'b1, 16'h0020, mk_wb(1'b1, 1'b0, 3'd2, 16'h0020, 1'b0, 1'b0)};
    vt[3] = '{1'b1, 3'b001, 3'b000, 3'd5, 16'h1234, 16'h0000, 16'h0008, 16'h0000,
              1'b0, 1'b0, 16'h1234, mk_wb(1'b1, 1'b1, 3'd5, 16'h1234, 1'b0, 1'b0)};
    vt[4] = '{1'b1, 3'b101, 3'b000, 3'd7, 16'h0007, 16'h0000, 16'h0042, 16'h0000,
              1'b0, 1'b0, 16'h0007, mk_wb(1'b1, 1'b1, 3'd7, 16'h0042, 1'b0, 1'b0)};
    vt[5] = '{1'b1, 3'b111, 3'b001, 3'd1, 16'h0050, 16'h0000, 16'h0099, 16'h0000,
              1'b0, 1'b0, 16'h0050, mk_wb(1'b1, 1'b1, 3'd1, 16'h0040, 1'b1, 1'b0)};
    vt[6] = '{1'b0, 3'b001, 3'b010, 3'd1, 16'h0060, 16'h1111, 16'h0000, 16'h0000,
              1'b0, 1'b0, 16'h0000, mk_wb(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0)};
    vt[7] = '{1'b1, 3'b011, 3'b101, 3'd0, 16'h0070, 16'h0000, 16'h0000, 16'h0000,
              1'b0, 1'b0, 16'h0000, mk_wb(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0)};
    vt[8] = '{1'b1, 3'b000, 3'b110, 3'd0, 16'h0080, 16'h2222, 16'h0000, 16'h0000,
              1'b0, 1'b0, 16'h0000, mk_wb(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0)};

    mem_init = 1'b1;
    reset    = 1'b1;
    set_ex(1'b1, 3'b001, 3'b010, 3'd1, 16'h0030, 16'h3333, 16'h0, 16'h0, 16'h0);
    #1;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_we", {31'd0, mem_we}, 32'd0);
    exp_q.push_back(mk_wb(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0));
    tick();
    mem_init = 1'b0;
    exp_q.push_back(mk_wb(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0));
    tick();
    reset = 1'b0;
    chk("reset_no_write", {16'd0, mem[16'h0030]}, {16'd0, dflt(16'h0030)});

    for (int n = 0; n < 9; n++) begin
      set_ex(vt[n].v, vt[n].wb, vt[n].m, vt[n].rd, vt[n].alu, vt[n].wd, vt[n].pc1,
             vt[n].inst, 16'h0300);
      #1;
      chk($sformatf("vec%0d_stall", n), {31'd0, stall}, {31'd0, vt[n].e_stall});
      chk($sformatf("vec%0d_we", n), {31'd0, mem_we}, {31'd0, vt[n].e_we});
      chk($sformatf("vec%0d_addr", n), {16'd0, mem_addr}, {16'd0, vt[n].e_addr});
      exp_q.push_back(vt[n].e_wb);
      tick();
    end
    chk("sw_stored", {16'd0, mem[16'h0020]}, 32'hBEEF);
    chk("invalid_no_store", {16'd0, mem[16'h0060]}, {16'd0, dflt(16'h0060)});
    chk("nop_sm_no_store", {16'd0, mem[16'h0080]}, {16'd0, dflt(16'h0080)});

    idle_cycle();
    run_multi("lm25", 1'b1, 8'h25, 16'h0100, -1);
    run_multi("sm81", 1'b0, 8'h81, 16'hFFFF, -1);
    run_multi("sma6", 1'b0, 8'hA6, 16'h0400, -1);
    run_multi("lmff_rst", 1'b1, 8'hFF, 16'h0200, 2);
    run_multi("smff_rst", 1'b0, 8'hFF, 16'h0500, 3);
    chk("sm_rst_no_more", {16'd0, mem[16'h0503]}, {16'd0, dflt(16'h0503)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
